// File: rtl/pc_sequencer.sv
// Program-counter sequencer driving the push/pop side of the return-address stack.
// Define PC_SEQ_STACK_TRAP_EN to trap stack overflow/underflow into a FAULT state.
module pc_sequencer #(
    parameter int                ADDR_W   = 11,
    parameter int                DEPTH    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic              cond,
    input  logic [ADDR_W-1:0] target,
    input  logic              clear_fault,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_valid,
    output logic              push_enable,
    output logic [ADDR_W-1:0] push_data,
    output logic              pop_enable,
    input  logic [ADDR_W-1:0] pop_data,
    output logic [5:0]        depth,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_BUBBLE = 2'd1;
    localparam logic [1:0] S_FAULT  = 2'd2;

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BRC  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    localparam logic [5:0] DEPTH_L = 6'(DEPTH);

    logic [1:0]        r_state, w_state_nx;
    logic [ADDR_W-1:0] r_pc, w_pc_nx, w_pc_inc;
    logic [5:0]        r_depth, w_depth_nx;
    logic              w_accept, w_full, w_empty, w_push, w_pop;
`ifdef PC_SEQ_STACK_TRAP_EN
    logic [1:0]        r_code, w_code_nx;
`endif

    always_comb begin
        w_pc_inc   = r_pc + ADDR_W'(1);
        w_accept   = en && (r_state == S_RUN);
        w_full     = (r_depth == DEPTH_L);
        w_empty    = (r_depth == 6'd0);
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_pc_nx    = r_pc;
        w_depth_nx = r_depth;
        w_state_nx = r_state;
`ifdef PC_SEQ_STACK_TRAP_EN
        w_code_nx  = r_code;
`endif
        case (r_state)
            S_RUN: begin
                if (w_accept) begin
                    case (op)
                        OP_JMP: begin
                            w_pc_nx    = target;
                            w_state_nx = S_BUBBLE;
                        end
                        OP_BRC: begin
                            if (cond) begin
                                w_pc_nx    = target;
                                w_state_nx = S_BUBBLE;
                            end else begin
                                w_pc_nx = w_pc_inc;
                            end
                        end
                        OP_CALL: begin
                            if (!w_full) begin
                                w_push     = 1'b1;
                                w_pc_nx    = target;
                                w_depth_nx = r_depth + 6'd1;
                                w_state_nx = S_BUBBLE;
                            end else begin
`ifdef PC_SEQ_STACK_TRAP_EN
                                w_state_nx = S_FAULT;
                                w_code_nx  = 2'b01;
`else
                                w_pc_nx    = target;
                                w_state_nx = S_BUBBLE;
`endif
                            end
                        end
                        OP_RET: begin
                            // pop_data is the live top-of-stack, consumed before the pop edge
                            if (!w_empty) begin
                                w_pop      = 1'b1;
                                w_pc_nx    = pop_data;
                                w_depth_nx = r_depth - 6'd1;
                                w_state_nx = S_BUBBLE;
                            end else begin
`ifdef PC_SEQ_STACK_TRAP_EN
                                w_state_nx = S_FAULT;
                                w_code_nx  = 2'b10;
`else
                                w_pc_nx    = w_pc_inc;
`endif
                            end
                        end
                        default: w_pc_nx = w_pc_inc;
                    endcase
                end
            end
            S_BUBBLE: w_state_nx = S_RUN;
            S_FAULT: begin
                if (clear_fault) begin
                    w_state_nx = S_RUN;
`ifdef PC_SEQ_STACK_TRAP_EN
                    w_code_nx  = 2'b00;
`endif
                end
            end
            default: w_state_nx = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_depth <= 6'd0;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
            r_depth <= w_depth_nx;
        end
    end

`ifdef PC_SEQ_STACK_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) r_code <= 2'b00;
        else     r_code <= w_code_nx;
    end

    assign fault      = (r_state == S_FAULT);
    assign fault_code = r_code;
`else
    assign fault      = 1'b0;
    assign fault_code = 2'b00;
`endif

    assign pc          = r_pc;
    assign fetch_valid = (r_state == S_RUN);
    assign push_enable = w_push;
    assign push_data   = w_pc_inc;
    assign pop_enable  = w_pop;
    assign depth       = r_depth;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; a reference model with its own return stack
// predicts each cycle. Honours PC_SEQ_STACK_TRAP_EN like the design.
module tb_pc_sequencer;

    localparam int DEPTH = 32;
    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BRC = 3'd2, CALL = 3'd3, RET = 3'd4;

    typedef struct packed {
        logic [10:0] pc;
        logic        fv;
        logic [5:0]  dep;
        logic        flt;
        logic [1:0]  code;
        logic        push;
        logic        pop;
        logic [10:0] pdata;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, cond = 1'b0, clear_fault = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [10:0] target = '0, pop_data = '0;
    logic [10:0] pc, push_data;
    logic        fetch_valid, push_enable, pop_enable, fault;
    logic [5:0]  depth;
    logic [1:0]  fault_code;

    logic [10:0] m_pc;
    int          m_state, m_depth;
    logic [1:0]  m_code;
    logic [10:0] m_stk [0:DEPTH-1];

    int          n_checks = 0, n_pass = 0;
    exp_t        sb_q[$];
    logic        obs_push, obs_pop;
    logic [10:0] obs_pdata;

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(11), .DEPTH(32), .RESET_PC(11'h000)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .cond(cond), .target(target),
        .clear_fault(clear_fault), .pc(pc), .fetch_valid(fetch_valid),
        .push_enable(push_enable), .push_data(push_data), .pop_enable(pop_enable),
        .pop_data(pop_data), .depth(depth), .fault(fault), .fault_code(fault_code)
    );

    task automatic model_reset();
        m_pc = 11'h000; m_state = 0; m_depth = 0; m_code = 2'b00;
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clear_fault = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one cycle; predicted comb outputs and post-edge state go to the scoreboard.
    task automatic step(input logic e, input logic [2:0] o, input logic c,
                        input logic [10:0] t, input logic clr);
        exp_t x;
        logic acc;
        en = e; op = o; cond = c; target = t; clear_fault = clr;
        pop_data = (m_depth > 0) ? m_stk[m_depth-1] : 11'h5A5;
        #1;
        obs_push = push_enable; obs_pop = pop_enable; obs_pdata = push_data;
        acc     = e && (m_state == 0);
        x.push  = acc && (o == CALL) && (m_depth < DEPTH);
        x.pop   = acc && (o == RET) && (m_depth > 0);
        x.pdata = m_pc + 11'd1;
        if (m_state == 1) m_state = 0;
        else if (m_state == 2) begin
            if (clr) begin m_state = 0; m_code = 2'b00; end
        end else if (acc) begin
            case (o)
                JMP: begin m_pc = t; m_state = 1; end
                BRC: if (c) begin m_pc = t; m_state = 1; end else m_pc = m_pc + 11'd1;
                CALL: if (m_depth < DEPTH) begin
                    m_stk[m_depth] = m_pc + 11'd1; m_depth++; m_pc = t; m_state = 1;
                end else begin
`ifdef PC_SEQ_STACK_TRAP_EN
                    m_state = 2; m_code = 2'b01;
`else
                    m_pc = t; m_state = 1;
`endif
                end
                RET: if (m_depth > 0) begin
                    m_depth--; m_pc = m_stk[m_depth]; m_state = 1;
                end else begin
`ifdef PC_SEQ_STACK_TRAP_EN
                    m_state = 2; m_code = 2'b10;
`else
                    m_pc = m_pc + 11'd1;
`endif
                end
                default: m_pc = m_pc + 11'd1;
            endcase
        end
        x.pc = m_pc; x.fv = (m_state == 0); x.dep = m_depth[5:0];
        x.flt = (m_state == 2); x.code = m_code;
        sb_q.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (pc !== 11'h000) $display("FAIL reset.pc got %h want 000", pc); else n_pass++;
        n_checks++; if (fetch_valid !== 1'b1) $display("FAIL reset.fetch_valid got %b want 1", fetch_valid); else n_pass++;
        n_checks++; if (depth !== 6'd0) $display("FAIL reset.depth got %0d want 0", depth); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL reset.fault got %b want 0", fault); else n_pass++;
        n_checks++; if (fault_code !== 2'b00) $display("FAIL reset.fault_code got %b want 00", fault_code); else n_pass++;
        n_checks++; if ({push_enable, pop_enable} !== 2'b00) $display("FAIL reset.enables got %b want 00", {push_enable, pop_enable}); else n_pass++;
    endtask

    task automatic test_seq();
        exp_t x;
        logic [2:0] ops [5] = '{SEQ, SEQ, SEQ, 3'd7, CALL};
        logic       ens [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(ens[i], ops[i], 1'b0, 11'h3AA, 1'b0);
            x = sb_q.pop_front();
            n_checks++;
            if ({pc, fetch_valid, depth, fault, fault_code} !== {x.pc, x.fv, x.dep, x.flt, x.code})
                $display("FAIL seq.regs[%0d] got pc=%h fv=%b dep=%0d flt=%b code=%b want pc=%h fv=%b dep=%0d flt=%b code=%b",
                         i, pc, fetch_valid, depth, fault, fault_code, x.pc, x.fv, x.dep, x.flt, x.code);
            else n_pass++;
            n_checks++;
            if ({obs_push, obs_pop, obs_pdata} !== {x.push, x.pop, x.pdata})
                $display("FAIL seq.stack[%0d] got push=%b pop=%b pdata=%h want push=%b pop=%b pdata=%h",
                         i, obs_push, obs_pop, obs_pdata, x.push, x.pop, x.pdata);
            else n_pass++;
        end
        n_checks++; if (pc !== 11'h004) $display("FAIL seq.final_pc got %h want 004", pc); else n_pass++;
    endtask

    task automatic test_call_ret();
        exp_t x;
        logic [2:0]  ops [6] = '{JMP, JMP, CALL, SEQ, RET, SEQ};
        logic [10:0] tgt [6] = '{11'h010, 11'h3FF, 11'h200, 11'h000, 11'h000, 11'h000};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ops[i], 1'b0, tgt[i], 1'b0);
            x = sb_q.pop_front();
            n_checks++;
            if ({pc, fetch_valid, depth, fault, fault_code} !== {x.pc, x.fv, x.dep, x.flt, x.code})
                $display("FAIL call_ret.regs[%0d] got pc=%h fv=%b dep=%0d flt=%b code=%b want pc=%h fv=%b dep=%0d flt=%b code=%b",
                         i, pc, fetch_valid, depth, fault, fault_code, x.pc, x.fv, x.dep, x.flt, x.code);
            else n_pass++;
            n_checks++;
            if ({obs_push, obs_pop, obs_pdata} !== {x.push, x.pop, x.pdata})
                $display("FAIL call_ret.stack[%0d] got push=%b pop=%b pdata=%h want push=%b pop=%b pdata=%h",
                         i, obs_push, obs_pop, obs_pdata, x.push, x.pop, x.pdata);
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if ({obs_push, obs_pdata, pc, fetch_valid, depth} !== {1'b1, 11'h011, 11'h200, 1'b0, 6'd1})
                    $display("FAIL call_ret.call got push=%b pdata=%h pc=%h fv=%b dep=%0d want push=1 pdata=011 pc=200 fv=0 dep=1",
                             obs_push, obs_pdata, pc, fetch_valid, depth);
                else n_pass++;
            end
            if (i == 4) begin
                n_checks++;
                if ({obs_pop, pc, depth} !== {1'b1, 11'h011, 6'd0})
                    $display("FAIL call_ret.ret got pop=%b pc=%h dep=%0d want pop=1 pc=011 dep=0", obs_pop, pc, depth);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        exp_t x;
        logic [2:0]  ops [6] = '{JMP, SEQ, CALL, SEQ, BRC, RET};
        logic [10:0] tgt [6] = '{11'h7FF, 11'h000, 11'h7FF, 11'h000, 11'h123, 11'h000};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ops[i], 1'b0, tgt[i], 1'b0);
            x = sb_q.pop_front();
            n_checks++;
            if ({pc, fetch_valid, depth, fault, fault_code} !== {x.pc, x.fv, x.dep, x.flt, x.code})
                $display("FAIL wrap.regs[%0d] got pc=%h fv=%b dep=%0d flt=%b code=%b want pc=%h fv=%b dep=%0d flt=%b code=%b",
                         i, pc, fetch_valid, depth, fault, fault_code, x.pc, x.fv, x.dep, x.flt, x.code);
            else n_pass++;
            n_checks++;
            if ({obs_push, obs_pop, obs_pdata} !== {x.push, x.pop, x.pdata})
                $display("FAIL wrap.stack[%0d] got push=%b pop=%b pdata=%h want push=%b pop=%b pdata=%h",
                         i, obs_push, obs_pop, obs_pdata, x.push, x.pop, x.pdata);
            else n_pass++;
            if (i == 2) begin
                n_checks++;
                if (obs_pdata !== 11'h000) $display("FAIL wrap.push_data got %h want 000", obs_pdata); else n_pass++;
            end
            if (i == 4) begin
                n_checks++;
                if ({pc, fetch_valid} !== {11'h000, 1'b1}) $display("FAIL wrap.brc got pc=%h fv=%b want pc=000 fv=1", pc, fetch_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow();
        exp_t x;
        logic [10:0] held;
        do_reset();
        for (int i = 0; i < 2 * DEPTH + 3; i++) begin
            if (i < 2 * DEPTH)       step(1'b1, (i % 2 == 0) ? CALL : SEQ, 1'b0, 11'(i * 8), 1'b0);
            else if (i == 2 * DEPTH) begin held = pc; step(1'b1, CALL, 1'b0, 11'h444, 1'b0); end
            else if (i == 2 * DEPTH + 1) step(1'b1, SEQ, 1'b0, 11'h000, 1'b0);
            else                     step(1'b1, SEQ, 1'b0, 11'h000, 1'b1);
            x = sb_q.pop_front();
            n_checks++;
            if ({pc, fetch_valid, depth, fault, fault_code} !== {x.pc, x.fv, x.dep, x.flt, x.code})
                $display("FAIL overflow.regs[%0d] got pc=%h fv=%b dep=%0d flt=%b code=%b want pc=%h fv=%b dep=%0d flt=%b code=%b",
                         i, pc, fetch_valid, depth, fault, fault_code, x.pc, x.fv, x.dep, x.flt, x.code);
            else n_pass++;
            n_checks++;
            if ({obs_push, obs_pop, obs_pdata} !== {x.push, x.pop, x.pdata})
                $display("FAIL overflow.stack[%0d] got push=%b pop=%b pdata=%h want push=%b pop=%b pdata=%h",
                         i, obs_push, obs_pop, obs_pdata, x.push, x.pop, x.pdata);
            else n_pass++;
            if (i == 2 * DEPTH) begin
                n_checks++;
`ifdef PC_SEQ_STACK_TRAP_EN
                if ({obs_push, fault, fault_code, pc, depth} !== {1'b0, 1'b1, 2'b01, held, 6'd32})
                    $display("FAIL overflow.trap got push=%b flt=%b code=%b pc=%h dep=%0d want push=0 flt=1 code=01 pc=%h dep=32",
                             obs_push, fault, fault_code, pc, depth, held);
`else
                if ({obs_push, pc, depth} !== {1'b0, 11'h444, 6'd32})
                    $display("FAIL overflow.full_call got push=%b pc=%h dep=%0d want push=0 pc=444 dep=32", obs_push, pc, depth);
`endif
                else n_pass++;
            end
        end
        n_checks++;
        if ({fault, fault_code, fetch_valid} !== {1'b0, 2'b00, 1'b1})
            $display("FAIL overflow.cleared got flt=%b code=%b fv=%b want flt=0 code=00 fv=1", fault, fault_code, fetch_valid);
        else n_pass++;
    endtask

    task automatic test_underflow();
        exp_t x;
        logic [2:0] ops [5] = '{JMP, SEQ, RET, RET, SEQ};
        logic       clr [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       any_pop = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ops[i], 1'b0, 11'h055, clr[i]);
            any_pop |= obs_pop;
            x = sb_q.pop_front();
            n_checks++;
            if ({pc, fetch_valid, depth, fault, fault_code} !== {x.pc, x.fv, x.dep, x.flt, x.code})
                $display("FAIL underflow.regs[%0d] got pc=%h fv=%b dep=%0d flt=%b code=%b want pc=%h fv=%b dep=%0d flt=%b code=%b",
                         i, pc, fetch_valid, depth, fault, fault_code, x.pc, x.fv, x.dep, x.flt, x.code);
            else n_pass++;
            if (i == 2) begin
                n_checks++;
`ifdef PC_SEQ_STACK_TRAP_EN
                if ({fault, fault_code, pc} !== {1'b1, 2'b10, 11'h055})
                    $display("FAIL underflow.trap got flt=%b code=%b pc=%h want flt=1 code=10 pc=055", fault, fault_code, pc);
`else
                if ({pc, fetch_valid} !== {11'h056, 1'b1})
                    $display("FAIL underflow.seq got pc=%h fv=%b want pc=056 fv=1", pc, fetch_valid);
`endif
                else n_pass++;
            end
        end
        n_checks++; if (any_pop !== 1'b0) $display("FAIL underflow.pop_enable got 1 want 0"); else n_pass++;
    endtask

    task automatic test_reset_bubble();
        exp_t x;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, (i % 2 == 0) ? CALL : SEQ, 1'b0, 11'(11'h100 + i), 1'b0);
            x = sb_q.pop_front();
            n_checks++;
            if ({pc, fetch_valid, depth} !== {x.pc, x.fv, x.dep})
                $display("FAIL rst_bubble.regs[%0d] got pc=%h fv=%b dep=%0d want pc=%h fv=%b dep=%0d",
                         i, pc, fetch_valid, depth, x.pc, x.fv, x.dep);
            else n_pass++;
        end
        n_checks++;
        if ({fetch_valid, depth} !== {1'b0, 6'd5}) $display("FAIL rst_bubble.pre got fv=%b dep=%0d want fv=0 dep=5", fetch_valid, depth);
        else n_pass++;
        rst = 1'b1; en = 1'b1; op = CALL;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        model_reset();
        n_checks++;
        if ({pc, depth, fetch_valid, fault} !== {11'h000, 6'd0, 1'b1, 1'b0})
            $display("FAIL rst_bubble.post got pc=%h dep=%0d fv=%b flt=%b want pc=000 dep=0 fv=1 flt=0", pc, depth, fetch_valid, fault);
        else n_pass++;
        step(1'b1, SEQ, 1'b0, 11'h000, 1'b0);
        x = sb_q.pop_front();
        n_checks++; if (pc !== x.pc) $display("FAIL rst_bubble.resume got pc=%h want %h", pc, x.pc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_call_ret();
        test_wrap();
        test_overflow();
        test_underflow();
        test_reset_bubble();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
